// File: rtl/priority_encoder_sync.sv
// priority_encoder_sync
//   Registered 8-to-3 priority encoder with debounce and a VALID/ACK handshake.
//   Pairs with the 3-to-8 active-low decoder: C/B/A are active-high and can
//   drive the decoder select inputs directly.
//
//   Optional build macro ENC_INSYNC_EN: when defined, I_N and EI_N pass through
//   2-flop synchronizers (reset to all-ones), adding 2 cycles to every path.
//
// Ports
//   CLK    in   system clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   EI_N   in   active-low enable
//   I_N    in   [7:0] active-low requests, bit 7 highest priority
//   ACK    in   consumer acknowledge, honoured only while VALID=1
//   C/B/A  out  qualified code bits 2/1/0
//   VALID  out  code is qualified and stable
//   GS_N   out  enabled and at least one request (active low)
//   EO_N   out  enabled and no request (active low)
module priority_encoder_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EI_N,
  input  logic [7:0] I_N,
  input  logic       ACK,
  output logic       C,
  output logic       B,
  output logic       A,
  output logic       VALID,
  output logic       GS_N,
  output logic       EO_N
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUAL    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Index of the highest-numbered low bit; 0 when none is low (req gates use).
  function automatic logic [2:0] pcode_f(input logic [7:0] req_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!req_n[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  logic [7:0] i_n_s;
  logic       ei_n_s;

`ifdef ENC_INSYNC_EN
  logic [7:0] i_n_meta_q;
  logic [7:0] i_n_sync_q;
  logic       ei_n_meta_q;
  logic       ei_n_sync_q;

  // Two-stage input synchronizers; idle (all-ones) out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      i_n_meta_q  <= 8'hFF;
      i_n_sync_q  <= 8'hFF;
      ei_n_meta_q <= 1'b1;
      ei_n_sync_q <= 1'b1;
    end else begin
      i_n_meta_q  <= I_N;
      i_n_sync_q  <= i_n_meta_q;
      ei_n_meta_q <= EI_N;
      ei_n_sync_q <= ei_n_meta_q;
    end
  end

  assign i_n_s  = i_n_sync_q;
  assign ei_n_s = ei_n_sync_q;
`else
  assign i_n_s  = I_N;
  assign ei_n_s = EI_N;
`endif

  logic       req_s;
  logic [2:0] pcode_s;

  assign req_s   = ~&i_n_s;
  assign pcode_s = pcode_f(i_n_s);

  state_t           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             gs_n_q, eo_n_q;

  // Group-select / enable-out flags: a pure registered function of the inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gs_n_q <= 1'b1;
      eo_n_q <= 1'b1;
    end else if (ei_n_s) begin
      gs_n_q <= 1'b1;
      eo_n_q <= 1'b1;
    end else if (req_s) begin
      gs_n_q <= 1'b0;
      eo_n_q <= 1'b1;
    end else begin
      gs_n_q <= 1'b1;
      eo_n_q <= 1'b0;
    end
  end

  // Handshake state machine: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (!ei_n_s && req_s) begin
          cand_d  = pcode_s;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_QUAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_QUAL: begin
        if (ei_n_s || !req_s) begin
          state_d = ST_IDLE;
        end else if (pcode_s != cand_q) begin
          // A higher (or different) line took over: restart the window on it.
          cand_d = pcode_s;
          cnt_d  = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          code_d  = cand_q;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // Inputs are ignored here; only the consumer can end the hold.
        if (ACK) begin
          valid_d = 1'b0;
          state_d = ST_RELEASE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        // Wait for the served line to let go so it is not reported twice.
        if (i_n_s[cand_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cand_q  <= 3'd0;
      cnt_q   <= {CNT_W{1'b0}};
      code_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign C     = code_q[2];
  assign B     = code_q[1];
  assign A     = code_q[0];
  assign VALID = valid_q;
  assign GS_N  = gs_n_q;
  assign EO_N  = eo_n_q;

endmodule
